stroke_interpolator: RTL and testbench

- Sits directly upstream of the frame buffer painter.
- Accepts sparse brush samples (position, colour, size, pen state) from the cursor/tracker stage.
- Emits a held brush position that walks the Bresenham line from the previous sample to the new one, so fast strokes paint without gaps.
- The painter only paints while its raster passes the brush. The output therefore advances only in bursts triggered by the new-frame pulse, and is held for the rest of each frame.

---
 rtl/stroke_interpolator.sv | 159 +++++++++++++++
 tb/tb_stroke_interpolator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/stroke_interpolator.sv
// Brush stroke interpolator: walks a Bresenham line between pen-down samples,
// advancing the held brush position only in bursts released by the new-frame pulse.
module stroke_interpolator #(
    parameter int H_RES = 640,
    parameter int V_RES = 360
) (
    input  logic       pixel_clk_in,
    input  logic       rst_in,
    input  logic       valid_in,
    output logic       ready_out,
    input  logic [9:0] x_in,
    input  logic [8:0] y_in,
    input  logic [3:0] color_in,
    input  logic [2:0] sw_in,
    input  logic       pen_down_in,
    input  logic       nf_in,
    output logic [9:0] x_out,
    output logic [8:0] y_out,
    output logic [3:0] color_out,
    output logic [2:0] sw_out,
    output logic       draw_en_out,
    output logic       busy_out
);

    typedef enum logic [1:0] {IDLE, SETUP, WAIT, STEP} state_t;

    localparam logic [9:0] X_MAX = 10'(H_RES - 1);
    localparam logic [8:0] Y_MAX = 9'(V_RES - 1);

    function automatic logic signed [11:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic signed [11:0] d;
        d = signed'({2'b00, a}) - signed'({2'b00, b});
        return (d < 12'sd0) ? -d : d;
    endfunction

    state_t            state_q, state_d;
    logic [9:0]        x_q, x_d, tx_q, tx_d;
    logic [8:0]        y_q, y_d, ty_q, ty_d;
    logic [3:0]        color_q, color_d, cnt_q, cnt_d;
    logic [2:0]        sw_q, sw_d;
    logic              draw_en_q, draw_en_d, have_prev_q, have_prev_d;
    logic              sx_q, sx_d, sy_q, sy_d, nf_pend_q, nf_pend_d;
    logic signed [11:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;

    logic              accept, same_pos, step_x, step_y, at_target;
    logic [9:0]        cx, x_step;
    logic [8:0]        cy, y_step;
    logic signed [11:0] setup_dx, setup_dy, err_step;
    logic signed [12:0] e2, dx_ext, dy_ext;

    always_comb begin
        accept    = valid_in && (state_q == IDLE);
        cx        = (x_in > X_MAX) ? X_MAX : x_in;
        cy        = (y_in > Y_MAX) ? Y_MAX : y_in;
        same_pos  = (cx == x_q) && (cy == y_q);
        setup_dx  = abs_diff(tx_q, x_q);
        setup_dy  = abs_diff({1'b0, ty_q}, {1'b0, y_q});
        // e2 is kept one bit wider than err so doubling cannot wrap
        e2        = {err_q, 1'b0};
        dx_ext    = {dx_q[11], dx_q};
        dy_ext    = {dy_q[11], dy_q};
        step_x    = (e2 >= dy_ext);
        step_y    = (e2 <= dx_ext);
        x_step    = step_x ? (sx_q ? x_q - 10'd1 : x_q + 10'd1) : x_q;
        y_step    = step_y ? (sy_q ? y_q - 9'd1 : y_q + 9'd1) : y_q;
        err_step  = err_q + (step_x ? dy_q : 12'sd0) + (step_y ? dx_q : 12'sd0);
        at_target = (x_step == tx_q) && (y_step == ty_q);
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && pen_down_in && have_prev_q && !same_pos) state_d = SETUP;
            SETUP:   state_d = WAIT;
            WAIT:    if (nf_in || nf_pend_q) state_d = STEP;
            STEP: begin
                if (at_target)          state_d = IDLE;
                else if (cnt_q == 4'd1) state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_out   = (state_q == IDLE);
        busy_out    = (state_q != IDLE);
        x_out       = x_q;
        y_out       = y_q;
        color_out   = color_q;
        sw_out      = sw_q;
        draw_en_out = draw_en_q;
    end

    always_comb begin
        x_d = x_q;  y_d = y_q;  tx_d = tx_q;  ty_d = ty_q;
        color_d = color_q;  sw_d = sw_q;  cnt_d = cnt_q;
        draw_en_d = draw_en_q;  have_prev_d = have_prev_q;
        sx_d = sx_q;  sy_d = sy_q;  nf_pend_d = nf_pend_q;
        dx_d = dx_q;  dy_d = dy_q;  err_d = err_q;
        case (state_q)
            IDLE: if (accept) begin
                color_d = color_in;
                sw_d    = sw_in;
                if (!pen_down_in) begin
                    x_d = cx;  y_d = cy;  draw_en_d = 1'b0;  have_prev_d = 1'b0;
                end else if (!have_prev_q) begin
                    x_d = cx;  y_d = cy;  draw_en_d = 1'b1;  have_prev_d = 1'b1;
                end else begin
                    draw_en_d = 1'b1;
                    if (!same_pos) begin
                        tx_d = cx;  ty_d = cy;
                    end
                end
            end
            SETUP: begin
                dx_d      = setup_dx;
                dy_d      = -setup_dy;
                err_d     = setup_dx - setup_dy;
                sx_d      = (tx_q < x_q);
                sy_d      = (ty_q < y_q);
                nf_pend_d = nf_in;
            end
            WAIT: if (nf_in || nf_pend_q) begin
                // burst length equals brush diameter so consecutive dabs overlap
                cnt_d     = {sw_q, 1'b1};
                nf_pend_d = 1'b0;
            end
            STEP: begin
                x_d   = x_step;
                y_d   = y_step;
                err_d = err_step;
                cnt_d = cnt_q - 4'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            x_q <= '0;  y_q <= '0;  tx_q <= '0;  ty_q <= '0;
            color_q <= '0;  sw_q <= '0;  cnt_q <= '0;
            draw_en_q <= 1'b0;  have_prev_q <= 1'b0;
            sx_q <= 1'b0;  sy_q <= 1'b0;  nf_pend_q <= 1'b0;
            dx_q <= '0;  dy_q <= '0;  err_q <= '0;
        end else begin
            x_q <= x_d;  y_q <= y_d;  tx_q <= tx_d;  ty_q <= ty_d;
            color_q <= color_d;  sw_q <= sw_d;  cnt_q <= cnt_d;
            draw_en_q <= draw_en_d;  have_prev_q <= have_prev_d;
            sx_q <= sx_d;  sy_q <= sy_d;  nf_pend_q <= nf_pend_d;
            dx_q <= dx_d;  dy_q <= dy_d;  err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_stroke_interpolator.sv
// Directed bench for stroke_interpolator: per-cycle vector table plus
// hand-written sequences for burst walks, busy rejection and async reset.
module tb_stroke_interpolator;

    logic       clk, rst_n, valid, ready, pen, nf, de, busy;
    logic [9:0] xi, xo;
    logic [8:0] yi, yo;
    logic [3:0] ci, co;
    logic [2:0] si, so;

    int checks = 0;
    int failures = 0;

    stroke_interpolator #(.H_RES(640), .V_RES(360)) dut (
        .pixel_clk_in(clk), .rst_in(rst_n), .valid_in(valid), .ready_out(ready),
        .x_in(xi), .y_in(yi), .color_in(ci), .sw_in(si), .pen_down_in(pen),
        .nf_in(nf), .x_out(xo), .y_out(yo), .color_out(co), .sw_out(so),
        .draw_en_out(de), .busy_out(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v, p, n;
        logic [9:0] x;
        logic [8:0] y;
        logic [3:0] c;
        logic [2:0] s;
        int         ex, ey, ede, ebz, erd, ec, es;
    } vec_t;

    function automatic vec_t mk(logic v, logic p, logic n, int x, int y, int c, int s,
                                int ex, int ey, int ede, int ebz, int erd, int ec, int es);
        vec_t r;
        r.v = v;  r.p = p;  r.n = n;
        r.x = 10'(x);  r.y = 9'(y);  r.c = 4'(c);  r.s = 3'(s);
        r.ex = ex;  r.ey = ey;  r.ede = ede;  r.ebz = ebz;  r.erd = erd;  r.ec = ec;  r.es = es;
        return r;
    endfunction

    // idle/nf cycle during the sw=2 walk (colour 3, size 2 latched)
    function automatic vec_t mkw(logic n, int ex, int ey, int ebz);
        return mk(1'b0, 1'b0, n, 0, 0, 0, 0, ex, ey, 1, ebz, 1 - ebz, 3, 2);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic p, int x, int y, int c, int s);
        valid = v;  pen = p;  xi = 10'(x);  yi = 9'(y);  ci = 4'(c);  si = 3'(s);
    endtask

    vec_t vecs[28];

    initial begin
        vecs[0]  = mk(1, 1, 0, 0, 0, 3, 2,  0, 0, 1, 0, 1, 3, 2);
        vecs[1]  = mk(1, 1, 0, 12, 5, 3, 2, 0, 0, 1, 1, 0, 3, 2);
        vecs[2]  = mkw(0, 0, 0, 1);
        vecs[3]  = mkw(1, 0, 0, 1);
        vecs[4]  = mkw(0, 1, 0, 1);
        vecs[5]  = mkw(0, 2, 1, 1);
        vecs[6]  = mkw(0, 3, 1, 1);
        vecs[7]  = mkw(0, 4, 2, 1);
        vecs[8]  = mkw(0, 5, 2, 1);
        vecs[9]  = mkw(0, 5, 2, 1);
        vecs[10] = mkw(1, 5, 2, 1);
        vecs[11] = mkw(0, 6, 3, 1);
        vecs[12] = mkw(0, 7, 3, 1);
        vecs[13] = mkw(0, 8, 3, 1);
        vecs[14] = mkw(0, 9, 4, 1);
        vecs[15] = mkw(0, 10, 4, 1);
        vecs[16] = mkw(1, 10, 4, 1);
        vecs[17] = mkw(0, 11, 5, 1);
        vecs[18] = mkw(0, 12, 5, 0);
        vecs[19] = mkw(0, 12, 5, 0);
        vecs[20] = mk(1, 0, 0, 100, 100, 5, 1,  100, 100, 0, 0, 1, 5, 1);
        vecs[21] = mk(1, 1, 0, 100, 100, 5, 1,  100, 100, 1, 0, 1, 5, 1);
        vecs[22] = mk(1, 0, 0, 300, 200, 9, 4,  300, 200, 0, 0, 1, 9, 4);
        vecs[23] = mk(1, 1, 0, 310, 200, 9, 4,  310, 200, 1, 0, 1, 9, 4);
        vecs[24] = mk(1, 0, 0, 700, 400, 1, 0,  639, 359, 0, 0, 1, 1, 0);
        vecs[25] = mk(1, 1, 0, 700, 400, 1, 0,  639, 359, 1, 0, 1, 1, 0);
        vecs[26] = mk(1, 1, 0, 639, 359, 6, 7,  639, 359, 1, 0, 1, 6, 7);
        vecs[27] = mk(1, 1, 0, 1023, 511, 15, 3, 639, 359, 1, 0, 1, 15, 3);

        rst_n = 1'b0;  nf = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        chk("rst.x", xo, 0);     chk("rst.y", yo, 0);
        chk("rst.col", co, 0);   chk("rst.sw", so, 0);
        chk("rst.de", de, 0);    chk("rst.busy", busy, 0);
        chk("rst.ready", ready, 1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 28; i++) begin
            drive(vecs[i].v, vecs[i].p, vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].s);
            nf = vecs[i].n;
            tick();
            chk($sformatf("v%0d.x", i), xo, vecs[i].ex);
            chk($sformatf("v%0d.y", i), yo, vecs[i].ey);
            chk($sformatf("v%0d.de", i), de, vecs[i].ede);
            chk($sformatf("v%0d.busy", i), busy, vecs[i].ebz);
            chk($sformatf("v%0d.ready", i), ready, vecs[i].erd);
            chk($sformatf("v%0d.col", i), co, vecs[i].ec);
            chk($sformatf("v%0d.sw", i), so, vecs[i].es);
        end
        drive(0, 0, 0, 0, 0, 0);
        nf = 1'b0;

        // sw=0 line (10,20)->(20,20); first nf lands during SETUP
        drive(1, 0, 10, 20, 2, 0);  tick();
        drive(1, 1, 10, 20, 2, 0);  tick();
        chk("a.jump.x", xo, 10);
        drive(1, 1, 20, 20, 2, 0);  tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("a.ready_fall", ready, 0);
        chk("a.busy_rise", busy, 1);
        nf = 1'b1;  tick();
        nf = 1'b0;  tick();
        tick();
        chk("a.pend.x", xo, 11);
        for (int i = 12; i <= 20; i++) begin
            nf = 1'b1;  tick();
            nf = 1'b0;  tick();
            chk($sformatf("a.step%0d.x", i), xo, i);
            tick();
            chk($sformatf("a.hold%0d.x", i), xo, i);
        end
        chk("a.end.y", yo, 20);
        chk("a.end.busy", busy, 0);
        chk("a.end.ready", ready, 1);
        chk("a.end.de", de, 1);

        // busy rejection: (5,5) held on valid during walk to (24,20)
        drive(1, 1, 24, 20, 4, 0);  tick();
        drive(1, 1, 5, 5, 8, 7);    tick();
        chk("b.ignored.sw", so, 0);
        for (int k = 1; k <= 4; k++) begin
            nf = 1'b1;  tick();
            nf = 1'b0;  tick();
            chk($sformatf("b.step%0d.x", k), xo, 20 + k);
        end
        chk("b.end.y", yo, 20);
        chk("b.end.ready", ready, 1);
        chk("b.end.col", co, 4);
        tick();
        chk("b.accept.ready", ready, 0);
        chk("b.accept.sw", so, 7);
        chk("b.accept.col", co, 8);
        chk("b.accept.x", xo, 24);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        nf = 1'b1;  tick();
        nf = 1'b0;
        tick();  tick();  tick();
        chk("c.walk.x", xo, 21);
        chk("c.walk.y", yo, 18);
        chk("c.walk.busy", busy, 1);

        // async reset between edges in the middle of a burst
        #2;
        rst_n = 1'b0;
        #1;
        chk("c.rst.x", xo, 0);      chk("c.rst.y", yo, 0);
        chk("c.rst.de", de, 0);     chk("c.rst.busy", busy, 0);
        chk("c.rst.ready", ready, 1);
        chk("c.rst.sw", so, 0);
        #1;
        rst_n = 1'b1;
        #1;
        drive(1, 1, 50, 60, 2, 3);  tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("c.jump.x", xo, 50);    chk("c.jump.y", yo, 60);
        chk("c.jump.de", de, 1);    chk("c.jump.busy", busy, 0);
        chk("c.jump.ready", ready, 1);
        chk("c.jump.col", co, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
